// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: ALUControl codes (also used by decode
// and the ALU), FSM state encoding and small opcode helpers.
package muldiv_pkg;

  localparam logic [3:0] MUL   = 4'b0100;
  localparam logic [3:0] UMULL = 4'b0101;
  localparam logic [3:0] SMULL = 4'b0110;
  localparam logic [3:0] DIV   = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MUL) || (op == UMULL) || (op == SMULL);
  endfunction

  function automatic logic is_valid_op(input logic [3:0] op);
    return is_mult_op(op) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle datapath: a shift-add multiply step or a
// restoring-division step (one quotient bit). Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           fits;

  // Division reuses the registers: mplier holds the dividend (quotient shifts in at the
  // bottom), acc[W-1:0] the partial remainder, mcand[W-1:0] the divisor.
  always_comb begin
    trial       = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    diff        = trial - {1'b0, mcand[WIDTH-1:0]};
    fits        = (trial >= {1'b0, mcand[WIDTH-1:0]});
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    if (is_div) begin
      mplier_next = {mplier[WIDTH-2:0], fits};
      acc_next    = '0;
      acc_next[WIDTH-1:0] = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end else begin
      mcand_next  = mcand << 1;
      mplier_next = mplier >> 1;
      acc_next    = mplier[0] ? (acc + mcand) : acc;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit (MUL, UMULL, SMULL, unsigned DIV), one bit per cycle.
// Define MULDIV_EARLY_EXIT_EN to end multiplies once the remaining multiplier bits are zero.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [1:0]       Flags,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  state_t             state_reg, state_next;
  logic [3:0]         op_reg;
  logic               sign_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] mcand_reg, acc_reg;
  logic [WIDTH-1:0]   mplier_reg;

  logic [2*WIDTH-1:0] mcand_step, acc_step;
  logic [WIDTH-1:0]   mplier_step;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               early_exit_en;
  logic               start_skip;
  logic               calc_last;
  logic               div_zero;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               flag_n, flag_z;

`ifdef MULDIV_EARLY_EXIT_EN
  assign early_exit_en = 1'b1;
`else
  assign early_exit_en = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div      (op_reg == DIV),
    .mcand       (mcand_reg),
    .mplier      (mplier_reg),
    .acc         (acc_reg),
    .mcand_next  (mcand_step),
    .mplier_next (mplier_step),
    .acc_next    (acc_step)
  );

  assign abs_a    = SrcA[WIDTH-1] ? -SrcA : SrcA;
  assign abs_b    = SrcB[WIDTH-1] ? -SrcB : SrcB;
  assign div_zero = (mcand_reg[WIDTH-1:0] == '0);

  // Zero divisor, unknown opcodes and (with early exit) a zero multiplier need no iterations.
  assign start_skip = ((ALUControl == DIV) && (SrcB == '0)) || !is_valid_op(ALUControl) ||
                      (early_exit_en && is_mult_op(ALUControl) && (SrcB == '0));
  assign calc_last  = (cnt_reg == '0) ||
                      (early_exit_en && is_mult_op(op_reg) && (mplier_step == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = start_skip ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (calc_last) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = start ? (start_skip ? FIX : CALC) : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    product = sign_reg ? -acc_reg : acc_reg;
    res_lo  = '0;
    res_hi  = '0;
    case (op_reg)
      MUL:          res_lo = acc_reg[WIDTH-1:0];
      UMULL, SMULL: {res_hi, res_lo} = product;
      DIV: begin
        if (div_zero) begin
          res_lo = '1;
          res_hi = mplier_reg;
        end else begin
          res_lo = mplier_reg;
          res_hi = acc_reg[WIDTH-1:0];
        end
      end
      default: ;
    endcase
    flag_n = ((op_reg == UMULL) || (op_reg == SMULL)) ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
    flag_z = (res_lo == '0) && (res_hi == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg     <= '0;
      sign_reg   <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      ResultLo   <= '0;
      ResultHi   <= '0;
      Flags      <= '0;
      DivZero    <= 1'b0;
    end else if (ready && start) begin
      op_reg   <= ALUControl;
      cnt_reg  <= CW'(WIDTH - 1);
      acc_reg  <= '0;
      sign_reg <= 1'b0;
      if (ALUControl == DIV) begin
        mcand_reg  <= {{WIDTH{1'b0}}, SrcB};
        mplier_reg <= SrcA;
      end else if (ALUControl == SMULL) begin
        mcand_reg  <= {{WIDTH{1'b0}}, abs_a};
        mplier_reg <= abs_b;
        sign_reg   <= SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
      end else begin
        mcand_reg  <= {{WIDTH{1'b0}}, SrcA};
        mplier_reg <= SrcB;
      end
    end else if (state_reg == CALC) begin
      mcand_reg  <= mcand_step;
      mplier_reg <= mplier_step;
      acc_reg    <= acc_step;
      cnt_reg    <= cnt_reg - 1'b1;
    end else if (state_reg == FIX) begin
      ResultLo <= res_lo;
      ResultHi <= res_hi;
      Flags    <= {flag_n, flag_z};
      if (op_reg == DIV) DivZero <= div_zero;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_UMULL = 4'b0101;
  localparam logic [3:0] OP_SMULL = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    ALUControl = '0;
  logic [W-1:0]  SrcA = '0, SrcB = '0;
  logic          ready, busy, done, DivZero;
  logic [W-1:0]  ResultLo, ResultHi;
  logic [1:0]    Flags;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
    .SrcA(SrcA), .SrcB(SrcB), .ready(ready), .busy(busy), .done(done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .Flags(Flags), .DivZero(DivZero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: results straight from integer arithmetic, latency from the operand values.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi, output logic [1:0] fl,
                       output logic upd_dz, output logic dzv, output int lat);
    logic [63:0]        p;
    logic signed [63:0] sp;
    logic [W-1:0]       m;
    int                 msb;
    lo = '0; hi = '0; upd_dz = 1'b0; dzv = 1'b0; lat = 2;
    p  = {32'b0, a} * {32'b0, b};
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (op)
      OP_MUL:   lo = p[31:0];
      OP_UMULL: {hi, lo} = p;
      OP_SMULL: {hi, lo} = sp;
      OP_DIV: begin
        upd_dz = 1'b1;
        if (b == 0) begin lo = '1; hi = a; dzv = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
    if (op == OP_MUL || op == OP_UMULL || op == OP_SMULL) begin
      m = (op == OP_SMULL && b[31]) ? -b : b;
      msb = -1;
      for (int i = 0; i < W; i++) if (m[i]) msb = i;
`ifdef MULDIV_EARLY_EXIT_EN
      lat = (msb < 0) ? 2 : 3 + msb;
`else
      lat = W + 2;
`endif
    end else if (op == OP_DIV) begin
      lat = (b == 0) ? 2 : W + 2;
    end
    fl[1] = (op == OP_UMULL || op == OP_SMULL) ? hi[31] : lo[31];
    fl[0] = (lo == 0) && (hi == 0);
  endtask

  // Cycle-by-cycle compare process.
  initial begin
    logic         pend, e_done, e_busy, e_ready, p_upd, p_dz;
    logic [W-1:0] p_lo, p_hi, v_lo, v_hi;
    logic [1:0]   p_fl, v_fl;
    logic         v_dz;
    int           dcyc, lat;
    pend = 0; dcyc = 0; v_lo = 0; v_hi = 0; v_fl = 0; v_dz = 0;
    p_lo = 0; p_hi = 0; p_fl = 0; p_upd = 0; p_dz = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 0; v_lo = 0; v_hi = 0; v_fl = 0; v_dz = 0;
        chk("reset ready", 64'(ready), 64'(1));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset results", {ResultHi, ResultLo}, 64'(0));
        chk("reset flags/dz", 64'({Flags, DivZero}), 64'(0));
      end else begin
        if (pend && cyc == dcyc) begin
          v_lo = p_lo; v_hi = p_hi; v_fl = p_fl;
          if (p_upd) v_dz = p_dz;
        end
        e_done  = pend && (cyc == dcyc);
        e_busy  = pend && (cyc < dcyc);
        e_ready = !e_busy;
        chk("ready", 64'(ready), 64'(e_ready));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("result_lo", 64'(ResultLo), 64'(v_lo));
        chk("result_hi", 64'(ResultHi), 64'(v_hi));
        chk("flags", 64'(Flags), 64'(v_fl));
        chk("divzero", 64'(DivZero), 64'(v_dz));
        if (e_done) pend = 0;
        if (start && e_ready) begin
          model(ALUControl, SrcA, SrcB, p_lo, p_hi, p_fl, p_upd, p_dz, lat);
          pend = 1;
          dcyc = cyc + lat;
        end
      end
    end
  end

  task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUControl = op; SrcA = a; SrcB = b; start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; ALUControl = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done timeout: actual=no done required=done within 60 cycles");
    end
    lat = cyc - t0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    launch(op, a, b);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    logic [3:0] op;
    logic [W-1:0] a, b;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Hand-computed cases
    do_op(OP_MUL, 7, 6, lat);
`ifdef MULDIV_EARLY_EXIT_EN
    chk("mul7x6 latency", 64'(lat), 64'(5));
`else
    chk("mul7x6 latency", 64'(lat), 64'(34));
`endif
    chk("mul7x6 lo", 64'(ResultLo), 64'(42));
    chk("mul7x6 hi", 64'(ResultHi), 64'(0));
    chk("mul7x6 flags", 64'(Flags), 64'(2'b00));

    do_op(OP_UMULL, 32'hFFFFFFFF, 2, lat);
    chk("umull hi", 64'(ResultHi), 64'(1));
    chk("umull lo", 64'(ResultLo), 64'(32'hFFFFFFFE));

    do_op(OP_SMULL, 32'hFFFFFFFD, 5, lat);
    chk("smull hi:lo", {ResultHi, ResultLo}, 64'hFFFFFFFF_FFFFFFF1);
    chk("smull N", 64'(Flags[1]), 64'(1));

    do_op(OP_DIV, 100, 7, lat);
    chk("div100/7 latency", 64'(lat), 64'(34));
    chk("div100/7 lo", 64'(ResultLo), 64'(14));
    chk("div100/7 hi", 64'(ResultHi), 64'(2));

    do_op(OP_DIV, 5, 0, lat);
    chk("div5/0 latency", 64'(lat), 64'(2));
    chk("div5/0 lo", 64'(ResultLo), 64'(32'hFFFFFFFF));
    chk("div5/0 hi", 64'(ResultHi), 64'(5));
    chk("div5/0 divzero", 64'(DivZero), 64'(1));

    do_op(4'b1010, 123, 456, lat);
    chk("badop latency", 64'(lat), 64'(2));
    chk("badop results", {ResultHi, ResultLo}, 64'(0));
    chk("badop flags", 64'(Flags), 64'(2'b01));

    // Reset in the middle of a multiply
    launch(OP_MUL, 3, 3);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'(0));
    chk("midreset done", 64'(done), 64'(0));
    chk("midreset ready", 64'(ready), 64'(1));
    chk("midreset results", {ResultHi, ResultLo}, 64'(0));
    chk("midreset flags/dz", 64'({Flags, DivZero}), 64'(0));
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: second start lands in the DONE cycle of the first
    do_op(OP_MUL, 11, 13, lat);
    chk("b2b first lo", 64'(ResultLo), 64'(143));
    do_op(OP_MUL, 1234, 5678, lat);
`ifdef MULDIV_EARLY_EXIT_EN
    chk("b2b latency", 64'(lat), 64'(15));
`else
    chk("b2b latency", 64'(lat), 64'(34));
`endif
    chk("b2b lo", 64'(ResultLo), 64'(7006652));

`ifdef MULDIV_EARLY_EXIT_EN
    do_op(OP_MUL, 9, 3, lat);
    chk("early mul9x3 latency", 64'(lat), 64'(4));
    chk("early mul9x3 lo", 64'(ResultLo), 64'(27));
`endif

    // Randomized traffic, including starts while busy and one reset pulse
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 1500) begin
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
      end
      op = ($urandom_range(0, 9) < 8) ? {2'b01, 2'($urandom)} : 4'($urandom);
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 255);
        1: a = 32'h80000000;
        2: a = 0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = $urandom_range(0, 255);
        1: b = 0;
        2: b = 32'hFFFFFFFF;
        3: b = 32'h1 << $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      ALUControl = op; SrcA = a; SrcB = b;
      start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
